interval_timer_bank: RTL
========================

// Module: interval_timer_bank
// PURPOSE
//  Parametrised successor to the traffic controller's time-parameter store.
//  Holds NUM_INTERVALS reprogrammable interval values (base/extended/yellow/...) with defaults.
//  Adds an integrated countdown timer that loads the selected interval and flags expiry.
//  Sits between the programming interface (prg_sync_in) and the main light-sequencing FSM.
// PARAMETERS
//  NUM_INTERVALS  4                     number of interval entries (>=2)
//  VALUE_W        4                     width of each interval value, in ticks
//  SEL_W          $clog2(NUM_INTERVALS) width of selector / interval_address
//  DEFAULTS       {4'd1,4'd2,4'd3,4'd6} packed reset values, entry 0 in LSBs (BASE=6,EXT=3,YEL=2,SPARE=1)
// PORTS
//  clk              in   1        system clock
//  sys_reset        in   1        synchronous, active-high reset
//  selector         in   SEL_W    entry to reprogram
//  reprogram_value  in   VALUE_W  new value for entry `selector`
//  prg_sync_in      in   1        program strobe, already synchronised to clk; acts on rising edge
//  interval_address in   SEL_W    entry to read / to load into timer
//  output_value     out  VALUE_W  registered params[interval_address]
//  start_timer      in   1        1-cycle pulse: load timer from params[interval_address]
//  tick_en          in   1        1-cycle time-base enable (e.g. 1 Hz)
//  time_left        out  VALUE_W  current countdown value
//  busy             out  1        timer running
//  expired          out  1        1-cycle pulse when countdown reaches 0
//  prg_ack          out  1        1-cycle pulse: write accepted
//  prg_error        out  1        1-cycle pulse: write rejected (value 0)
// BEHAVIOUR
//  Reset: params <= DEFAULTS; output_value, time_left <= 0; busy, expired, prg_ack, prg_error <= 0;
//   prg_sync_in edge-detect register <= 0; FSM <= IDLE. Reset mid-count abandons count; no expired pulse.
//  Programming: rising edge = prg_sync_in & ~prg_q. Level held high writes once only.
//   reprogram_value != 0: params[selector] <= value, prg_ack the following cycle.
//   reprogram_value == 0: no write, prg_error the following cycle (zero interval is illegal).
//  Read: output_value <= params[interval_address] every cycle; 1-cycle latency; reflects a write
//   one cycle after the write cycle.
//  Timer FSM, states IDLE, RUN:
//   IDLE: start_timer -> time_left <= params[interval_address], busy <= 1, -> RUN.
//   RUN: tick_en -> time_left <= time_left-1; when time_left==1 and tick_en: time_left <= 0,
//    expired <= 1 (one cycle), busy <= 0, -> IDLE.
//   RUN + start_timer: restart with new load, no expired pulse; start wins over a same-cycle tick.
//   tick_en in IDLE ignored; time_left holds 0 after expiry.
//  Simultaneous write and start on same entry: timer loads the OLD value (read-before-write).
//  Writes while RUN never alter the running count; they take effect at the next load.
//  Arithmetic: unsigned, VALUE_W bits; decrement never wraps (value 0 unreachable in RUN).
//  Out-of-range index (NUM_INTERVALS not a power of 2): write ignored with prg_error; read returns 0;
//   start loads nothing and asserts expired next cycle.
// STRUCTURE
//  Shared package traffic_pkg: interval index constants (IDX_BASE=0, IDX_EXT=1, IDX_YEL=2, IDX_SPARE=3),
//   default value constants, timer state enum {IDLE, RUN}.
//  Sub-module interval_countdown (load/tick/time_left/busy/expired) instantiated once; the parameter
//   register file, edge detect and read mux stay at top level.
// TESTING
//  1. Reset, sweep interval_address 0..3 -> output_value 6,3,2,1 one cycle after each change.
//  2. selector=1, value=4'b1010, prg_sync_in held high 5 cycles -> single prg_ack, addr 1 reads 10.
//  3. value=0, prg_sync_in rising edge -> prg_error pulse, entry unchanged; then sys_reset -> addr 1 reads 3.
//  4. addr=2, start_timer, tick_en every 4th cycle -> time_left 2,1,0; expired one cycle; busy drops.
//  5. Start on addr 0 (6), after 2 ticks start on addr 2 -> reload 2, no expired for aborted count.
//  6. Same cycle start + write 9 to addr 0 -> timer loads 6; next start loads 9; reset mid-RUN -> busy=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic controller interval store and timer:
// interval index constants, default tick values and the timer state type.
package traffic_pkg;

    localparam int unsigned IDX_BASE  = 0;
    localparam int unsigned IDX_EXT   = 1;
    localparam int unsigned IDX_YEL   = 2;
    localparam int unsigned IDX_SPARE = 3;

    localparam logic [3:0] DEF_BASE  = 4'd6;
    localparam logic [3:0] DEF_EXT   = 4'd3;
    localparam logic [3:0] DEF_YEL   = 4'd2;
    localparam logic [3:0] DEF_SPARE = 4'd1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_e;

endpackage

// File: rtl/interval_countdown.sv
// Loadable countdown timer. A load starts (or restarts) the count and takes
// priority over a same-cycle tick; reaching zero raises a one-cycle expired
// pulse and returns to IDLE. A zero load expires on the next cycle.
module interval_countdown
    import traffic_pkg::*;
#(
    parameter int unsigned VALUE_W = 4
) (
    input  logic               clk,
    input  logic               sys_reset,
    input  logic               load_i,
    input  logic [VALUE_W-1:0] load_value_i,
    input  logic               tick_en_i,
    output logic [VALUE_W-1:0] time_left_o,
    output logic               busy_o,
    output logic               expired_o
);

    timer_state_e       state_q, state_d;
    logic [VALUE_W-1:0] time_left_q, time_left_d;
    logic               busy_q, busy_d;
    logic               expired_q, expired_d;

    // State and output registers; reset abandons any count silently.
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state_q     <= IDLE;
            time_left_q <= '0;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_left_q <= time_left_d;
            busy_q      <= busy_d;
            expired_q   <= expired_d;
        end
    end

    // Next-state logic: load wins over tick, decrement stops at zero.
    always_comb begin
        state_d     = state_q;
        time_left_d = time_left_q;
        busy_d      = busy_q;
        expired_d   = 1'b0;

        if (load_i) begin
            if (load_value_i == '0) begin
                // Nothing to count: expire immediately, stay idle.
                time_left_d = '0;
                busy_d      = 1'b0;
                expired_d   = 1'b1;
                state_d     = IDLE;
            end else begin
                time_left_d = load_value_i;
                busy_d      = 1'b1;
                state_d     = RUN;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    busy_d = 1'b0;
                end
                RUN: begin
                    if (tick_en_i) begin
                        if (time_left_q == VALUE_W'(1)) begin
                            time_left_d = '0;
                            busy_d      = 1'b0;
                            expired_d   = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            time_left_d = time_left_q - VALUE_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign time_left_o = time_left_q;
    assign busy_o      = busy_q;
    assign expired_o   = expired_q;

endmodule

// File: rtl/interval_timer_bank.sv
// Reprogrammable interval store with registered read port and an integrated
// countdown timer loaded from the addressed entry. Writes act on the rising
// edge of the programming strobe; zero values and bad selectors are rejected.
module interval_timer_bank
    import traffic_pkg::*;
#(
    parameter int unsigned                        NUM_INTERVALS = 4,
    parameter int unsigned                        VALUE_W       = 4,
    parameter int unsigned                        SEL_W         = $clog2(NUM_INTERVALS),
    parameter logic [NUM_INTERVALS*VALUE_W-1:0]   DEFAULTS      = {DEF_SPARE, DEF_YEL, DEF_EXT, DEF_BASE}
) (
    input  logic               clk,
    input  logic               sys_reset,
    input  logic [SEL_W-1:0]   selector,
    input  logic [VALUE_W-1:0] reprogram_value,
    input  logic               prg_sync_in,
    input  logic [SEL_W-1:0]   interval_address,
    output logic [VALUE_W-1:0] output_value,
    input  logic               start_timer,
    input  logic               tick_en,
    output logic [VALUE_W-1:0] time_left,
    output logic               busy,
    output logic               expired,
    output logic               prg_ack,
    output logic               prg_error
);

    logic [VALUE_W-1:0] params_q [NUM_INTERVALS];
    logic               prg_q;
    logic               prg_ack_q, prg_ack_d;
    logic               prg_error_q, prg_error_d;
    logic [VALUE_W-1:0] output_value_q, output_value_d;

    logic               prg_rise;
    logic               sel_ok;
    logic               addr_ok;
    logic               write_en;
    logic [VALUE_W-1:0] rd_value;

    assign prg_rise = prg_sync_in & ~prg_q;
    assign sel_ok   = (32'(selector) < NUM_INTERVALS);
    assign addr_ok  = (32'(interval_address) < NUM_INTERVALS);
    assign write_en = prg_rise & sel_ok & (reprogram_value != '0);

    // Combinational read of the current (pre-write) entry; feeds both the
    // registered read port and the timer load, giving read-before-write.
    always_comb begin
        rd_value = '0;
        if (addr_ok) begin
            rd_value = params_q[interval_address];
        end
    end

    // Handshake and read-port next values.
    always_comb begin
        prg_ack_d      = write_en;
        prg_error_d    = prg_rise & ~write_en;
        output_value_d = rd_value;
    end

    // Parameter file, strobe edge detect and registered outputs.
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            for (int unsigned i = 0; i < NUM_INTERVALS; i++) begin
                params_q[i] <= DEFAULTS[i*VALUE_W +: VALUE_W];
            end
            prg_q          <= 1'b0;
            prg_ack_q      <= 1'b0;
            prg_error_q    <= 1'b0;
            output_value_q <= '0;
        end else begin
            if (write_en) begin
                params_q[selector] <= reprogram_value;
            end
            prg_q          <= prg_sync_in;
            prg_ack_q      <= prg_ack_d;
            prg_error_q    <= prg_error_d;
            output_value_q <= output_value_d;
        end
    end

    interval_countdown #(
        .VALUE_W(VALUE_W)
    ) u_countdown (
        .clk         (clk),
        .sys_reset   (sys_reset),
        .load_i      (start_timer),
        .load_value_i(rd_value),
        .tick_en_i   (tick_en),
        .time_left_o (time_left),
        .busy_o      (busy),
        .expired_o   (expired)
    );

    assign output_value = output_value_q;
    assign prg_ack      = prg_ack_q;
    assign prg_error    = prg_error_q;

endmodule
